morse_transmitter: RTL and testbench

- Consumes the one-cycle `Enable` tick from the rate divider; each tick is one Morse time unit.
- Serialises a fixed Morse pattern for letters A–H onto a single LED output.
- Appends an inter-letter gap after each letter, then signals completion.
- Sits directly downstream of the rate divider; its `LedOut` drives a board LED.

---
 rtl/morse_transmitter_if.sv | 33 +++
 rtl/morse_transmitter.sv | 145 ++++++++++++++
 tb/tb_morse_transmitter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_transmitter_if.sv
// ---------------------------------------------------------------------------
// morse_transmitter_if
// Groups the rate-divider tick, the send request and the LED/status outputs
// of the Morse transmitter into one bundle.
//   Enable  : one-cycle unit tick from the rate divider
//   Start   : request to send a letter
//   Letter  : letter select, 0=A .. 7=H
//   Repeat  : (only with MORSE_REPEAT_EN) resend the latched letter
//   LedOut  : Morse output, 1 = lit
//   Busy    : letter or gap in progress
//   Done    : one-cycle pulse at the end of the gap
// Modports: master = requester/bench side, slave = transmitter side.
// Optional feature macro: MORSE_REPEAT_EN.
// ---------------------------------------------------------------------------
interface morse_transmitter_if;
  logic       Enable;
  logic       Start;
  logic [2:0] Letter;
`ifdef MORSE_REPEAT_EN
  logic       Repeat;
`endif
  logic       LedOut;
  logic       Busy;
  logic       Done;

`ifdef MORSE_REPEAT_EN
  modport master (output Enable, Start, Letter, Repeat, input LedOut, Busy, Done);
  modport slave  (input Enable, Start, Letter, Repeat, output LedOut, Busy, Done);
`else
  modport master (output Enable, Start, Letter, input LedOut, Busy, Done);
  modport slave  (input Enable, Start, Letter, output LedOut, Busy, Done);
`endif
endinterface

// File: rtl/morse_transmitter.sv
// ---------------------------------------------------------------------------
// morse_transmitter
// Serialises the Morse pattern of a letter A..H onto one LED, one pattern bit
// per Enable tick (MSB first), then holds the LED dark for GAP_UNITS ticks and
// pulses Done. All outputs are registered.
// Ports:
//   i_ClockIn : system clock, posedge
//   i_Reset   : synchronous, active-high reset
//   bus       : morse_transmitter_if.slave (Enable, Start, Letter, [Repeat],
//               LedOut, Busy, Done)
// Parameter: GAP_UNITS (1..7) dark units appended after the pattern.
// Optional feature macro: MORSE_REPEAT_EN adds Repeat; when high at the end
// of a gap the latched letter is resent instead of finishing.
// ---------------------------------------------------------------------------
module morse_transmitter #(
  parameter int GAP_UNITS = 3
) (
  input logic                  i_ClockIn,
  input logic                  i_Reset,
  morse_transmitter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [11:0] r_shift;
  logic [3:0]  r_bits_left;
  logic [2:0]  r_gap_left;
  logic [2:0]  r_letter;
  logic        r_led;
  logic        r_busy;
  logic        r_done;
  logic        w_repeat;

  // Patterns held left-aligned so the next bit is always r_shift[11].
  function automatic logic [11:0] f_pattern(input logic [2:0] letter);
    logic [11:0] pat;
    case (letter)
      3'd0:    pat = 12'b1011_1000_0000; // A 10111
      3'd1:    pat = 12'b1110_1010_1000; // B 111010101
      3'd2:    pat = 12'b1110_1011_1010; // C 11101011101
      3'd3:    pat = 12'b1110_1010_0000; // D 1110101
      3'd4:    pat = 12'b1000_0000_0000; // E 1
      3'd5:    pat = 12'b1010_1110_1000; // F 101011101
      3'd6:    pat = 12'b1110_1110_1000; // G 111011101
      3'd7:    pat = 12'b1010_1010_0000; // H 1010101
      default: pat = 12'b0000_0000_0000;
    endcase
    return pat;
  endfunction

  function automatic logic [3:0] f_length(input logic [2:0] letter);
    logic [3:0] len;
    case (letter)
      3'd0:    len = 4'd5;
      3'd1:    len = 4'd9;
      3'd2:    len = 4'd11;
      3'd3:    len = 4'd7;
      3'd4:    len = 4'd1;
      3'd5:    len = 4'd9;
      3'd6:    len = 4'd9;
      3'd7:    len = 4'd7;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

`ifdef MORSE_REPEAT_EN
  assign w_repeat = bus.Repeat;
`else
  assign w_repeat = 1'b0;
`endif

  assign bus.LedOut = r_led;
  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;

  // Transmit FSM: pattern shift-out, gap countdown and status outputs.
  always_ff @(posedge i_ClockIn) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_shift     <= 12'd0;
      r_bits_left <= 4'd0;
      r_gap_left  <= 3'd0;
      r_letter    <= 3'd0;
      r_led       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_led <= 1'b0;
          // An Enable in the accepting cycle is deliberately not consumed.
          if (bus.Start) begin
            r_shift     <= f_pattern(bus.Letter);
            r_bits_left <= f_length(bus.Letter);
            r_letter    <= bus.Letter;
            r_busy      <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (bus.Enable) begin
            if (r_bits_left != 4'd0) begin
              r_led       <= r_shift[11];
              r_shift     <= {r_shift[10:0], 1'b0};
              r_bits_left <= r_bits_left - 4'd1;
            end else begin
              // The tick after the last bit is the first dark gap unit.
              r_led      <= 1'b0;
              r_gap_left <= 3'(GAP_UNITS);
              r_state    <= GAP;
            end
          end
        end
        GAP: begin
          if (bus.Enable) begin
            if (r_gap_left > 3'd1) begin
              r_gap_left <= r_gap_left - 3'd1;
            end else if (w_repeat) begin
              r_shift     <= f_pattern(r_letter);
              r_bits_left <= f_length(r_letter);
              r_state     <= SEND;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_transmitter.sv
// ---------------------------------------------------------------------------
// tb_morse_transmitter
// Directed stimulus with a scoreboard: each accepted letter pushes the
// expected per-tick LED sequence (pattern bits then GAP_UNITS+1 dark ticks);
// a monitor collects LedOut at every Enable tick while Busy and compares the
// collection with the queue head on each Done pulse.
// ---------------------------------------------------------------------------
module tb_morse_transmitter;

  typedef struct {
    int          len;
    logic [63:0] bits;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   done_cnt;
  int   en_period;
  int   en_cnt;
  exp_t exp_q[$];

  logic        tick;
  int          ncoll;
  logic [63:0] coll;

  morse_transmitter_if bus ();

  morse_transmitter #(.GAP_UNITS(3)) dut (
    .i_ClockIn (clk),
    .i_Reset   (rst),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable generator: tied high (period 1) or one tick every en_period cycles.
  always @(negedge clk) begin
    #1;
    en_cnt = en_cnt + 1;
    if (en_period <= 1) bus.Enable = 1'b1;
    else bus.Enable = ((en_cnt % en_period) == 0);
  end

  // Note which edges are Enable ticks of a transmission in progress.
  always @(posedge clk) begin
    tick = bus.Enable && bus.Busy && !rst;
  end

  // Monitor: collect per-tick LED values, check against scoreboard on Done.
  always @(negedge clk) begin
    if (rst) begin
      ncoll = 0;
      coll  = 64'd0;
    end else begin
      if (tick) begin
        coll  = {coll[62:0], bus.LedOut};
        ncoll = ncoll + 1;
      end
      if (bus.Done) begin
        exp_t e;
        done_cnt = done_cnt + 1;
        n_tests  = n_tests + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_done: got Done with %0d ticks 0x%0h, required no Done", ncoll, coll);
        end else begin
          e = exp_q.pop_front();
          if (e.len != ncoll || e.bits != coll) begin
            n_fail = n_fail + 1;
            $display("FAIL seq_%s: got %0d ticks 0x%0h, required %0d ticks 0x%0h",
                     e.name, ncoll, coll, e.len, e.bits);
          end
        end
        n_tests = n_tests + 1;
        if (bus.Busy !== 1'b0) begin
          n_fail = n_fail + 1;
          $display("FAIL done_busy: got Busy=%b with Done, required 0", bus.Busy);
        end
        ncoll = 0;
        coll  = 64'd0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic act, input logic req);
    n_tests = n_tests + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input int len, input logic [63:0] bits);
    exp_t e;
    e.name = name;
    e.len  = len;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  // Issue a one-cycle Start for the given letter.
  task automatic send(input logic [2:0] letter);
    bus.Letter = letter;
    bus.Start  = 1'b1;
    step();
    bus.Start  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cycles);
    int n;
    n = 0;
    while (done_cnt < target && n < max_cycles) begin
      step();
      n = n + 1;
    end
    n_tests = n_tests + 1;
    if (done_cnt < target) begin
      n_fail = n_fail + 1;
      $display("FAIL timeout_done: got %0d Done pulses, required %0d", done_cnt, target);
    end
  endtask

  logic [10:0] led_v;
  logic [10:0] busy_v;
  logic [10:0] done_v;

  initial begin
    int lit;
    int n;
    n_tests   = 0;
    n_fail    = 0;
    done_cnt  = 0;
    en_period = 1;
    en_cnt    = 0;
    ncoll     = 0;
    coll      = 64'd0;
    tick      = 1'b0;
    bus.Enable = 1'b1;
    bus.Start  = 1'b0;
    bus.Letter = 3'd0;
`ifdef MORSE_REPEAT_EN
    bus.Repeat = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    check("reset_led",  bus.LedOut, 1'b0);
    check("reset_busy", bus.Busy,   1'b0);
    check("reset_done", bus.Done,   1'b0);
    rst = 1'b0;
    step();

    // A with Enable tied high; Start and Enable coincide in IDLE.
    led_v  = 11'b01011100000;
    busy_v = 11'b11111111100;
    done_v = 11'b00000000010;
    push_exp("A", 9, 64'b101110000);
    bus.Letter = 3'd0;
    bus.Start  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check($sformatf("A_led_%0d", i),  bus.LedOut, led_v[10-i]);
      check($sformatf("A_busy_%0d", i), bus.Busy,   busy_v[10-i]);
      check($sformatf("A_done_%0d", i), bus.Done,   done_v[10-i]);
      bus.Start = 1'b0;
    end
    wait_done(1, 50);

    // E with Enable every 4th cycle; Start lands on an Enable cycle.
    en_period = 4;
    step();
    n = 0;
    while (bus.Enable !== 1'b1 && n < 10) begin
      step();
      n = n + 1;
    end
    push_exp("E", 5, 64'b10000);
    bus.Letter = 3'd4;
    bus.Start  = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    lit = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (bus.LedOut) lit = lit + 1;
    end
    n_tests = n_tests + 1;
    if (lit != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL E_start_tick_used: got %0d lit cycles before next tick, required 0", lit);
    end
    @(negedge clk);
    check("E_first_bit", bus.LedOut, 1'b1);
    lit = 1;
    n = 0;
    while (done_cnt < 2 && n < 60) begin
      @(negedge clk);
      if (bus.LedOut) lit = lit + 1;
      n = n + 1;
    end
    n_tests = n_tests + 1;
    if (lit != 4) begin
      n_fail = n_fail + 1;
      $display("FAIL E_lit_cycles: got %0d, required 4", lit);
    end
    wait_done(2, 10);
    en_period = 1;
    repeat (3) step();

    // C interrupted by reset after the 4th bit, then H.
    bus.Letter = 3'd2;
    bus.Start  = 1'b1;
    repeat (5) @(negedge clk);
    bus.Start = 1'b0;
    check("C_bit4", bus.LedOut, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("C_rst_led",  bus.LedOut, 1'b0);
    check("C_rst_busy", bus.Busy,   1'b0);
    check("C_rst_done", bus.Done,   1'b0);
    rst = 1'b0;
    repeat (20) step();
    n_tests = n_tests + 1;
    if (done_cnt != 2) begin
      n_fail = n_fail + 1;
      $display("FAIL C_no_done: got %0d Done pulses, required 2", done_cnt);
    end
    push_exp("H", 11, 64'b10101010000);
    send(3'd7);
    wait_done(3, 50);
    repeat (2) step();

    // B with an ignored Start for D in the middle.
    push_exp("B", 13, 64'b1110101010000);
    send(3'd1);
    repeat (3) step();
    send(3'd3);
    bus.Letter = 3'd6;
    wait_done(4, 50);
    repeat (20) step();
    n_tests = n_tests + 1;
    if (done_cnt != 4 || exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL B_single_done: got %0d Done pulses, %0d pending, required 4 and 0",
               done_cnt, exp_q.size());
    end

`ifdef MORSE_REPEAT_EN
    // E repeated three times, Repeat dropped during the third gap.
    push_exp("E_rep", 15, 64'b100001000010000);
    bus.Repeat = 1'b1;
    send(3'd4);
    repeat (11) @(negedge clk);
    bus.Repeat = 1'b0;
    wait_done(5, 50);
    repeat (5) step();
`endif

    n_tests = n_tests + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
